// File: rtl/audio_voice_mixer.sv
// rtl/audio_voice_mixer.sv - multi-voice oscillator bank with time-multiplexed mixer and PWM output
// Each sample period, voices are visited one per cycle and summed; the average drives sample and PWM.
module audio_voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int ACC_W      = 16,
  parameter int OUT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_VOICES)-1:0] wr_voice,
  input  logic                          wr_addr,
  input  logic [ACC_W-1:0]              wr_data,
  output logic [OUT_W-1:0]              sample,
  output logic                          sample_valid,
  output logic                          pwm_out
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam int AW = OUT_W + VW;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  logic [ACC_W-1:0] inc   [NUM_VOICES];
  logic [ACC_W-1:0] phase [NUM_VOICES];
  logic [1:0]       mode  [NUM_VOICES];
  logic [1:0]       vol   [NUM_VOICES];

  state_t           state;
  logic [VW-1:0]    idx;
  logic [AW-1:0]    acc;
  logic [OUT_W-1:0] div_cnt;
  logic [OUT_W-1:0] pwm_level;

  logic             tick;
  logic [OUT_W-1:0] cur_wave;
  logic [OUT_W-1:0] cur_val;
  logic [AW-1:0]    acc_next;

  function automatic logic [OUT_W-1:0] wave_of(input logic [1:0] m, input logic [ACC_W-1:0] p);
    logic [OUT_W-1:0] t;
    t = p[ACC_W-2 -: OUT_W];
    case (m)
      2'd1:    wave_of = {OUT_W{p[ACC_W-1]}};
      2'd2:    wave_of = p[ACC_W-1 -: OUT_W];
      2'd3:    wave_of = p[ACC_W-1] ? ~t : t;
      default: wave_of = '0;
    endcase
  endfunction

  always_comb begin
    tick     = (div_cnt == {OUT_W{1'b1}});
    cur_wave = wave_of(mode[idx], phase[idx]);
    cur_val  = cur_wave >> vol[idx];
    acc_next = acc + AW'(cur_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        inc[i]   <= '0;
        phase[i] <= '0;
        mode[i]  <= '0;
        vol[i]   <= '0;
      end
      state        <= IDLE;
      idx          <= '0;
      acc          <= '0;
      div_cnt      <= '0;
      pwm_level    <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      pwm_out      <= 1'b0;
    end else begin
      div_cnt      <= div_cnt + 1'b1;
      pwm_out      <= (div_cnt < pwm_level);
      sample_valid <= 1'b0;
      if (tick)
        pwm_level <= sample;

      case (state)
        IDLE: begin
          if (tick) begin
            state <= ACCUM;
            idx   <= '0;
            acc   <= '0;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          if (mode[idx] != 2'd0)
            phase[idx] <= phase[idx] + inc[idx];
          if (idx == VW'(NUM_VOICES - 1)) begin
            state        <= DONE;
            sample       <= acc_next[AW-1:VW];
            sample_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Register writes come last so a same-cycle mode-0 clear overrides the phase step.
      if (wr_en) begin
        if (!wr_addr) begin
          inc[wr_voice] <= wr_data;
        end else begin
          mode[wr_voice] <= wr_data[1:0];
          vol[wr_voice]  <= wr_data[3:2];
          if (wr_data[1:0] == 2'd0)
            phase[wr_voice] <= '0;
        end
      end
    end
  end
endmodule

// File: doc/audio_voice_mixer.md
# audio_voice_mixer

Multi-voice tone generator and mixer for the audio chip datapath. Holds NUM_VOICES programmable oscillators (phase accumulators with selectable square/saw/triangle shape and 2-bit attenuation), sums them once per sample period with a time-multiplexed accumulator, and emits the averaged sample both as a parallel word and as a PWM bitstream for the output pin. Sits between the top-level register-write decode and the audio output pad.

## Interface

- NUM_VOICES, 4, number of oscillators; power of two, ≥2
- ACC_W, 16, phase accumulator / increment width; ≥10
- OUT_W, 8, sample width; sample period = 2^OUT_W clocks; 2^OUT_W ≥ NUM_VOICES+2

- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- wr_en  in  1  write strobe, one register write per asserted cycle
- wr_voice  in  log2(NUM_VOICES)  target voice
- wr_addr  in  1  0 = increment register, 1 = control register
- wr_data  in  ACC_W  write data
- sample  out  OUT_W  mixed sample, unsigned
- sample_valid  out  1  one-cycle strobe when sample updates
- pwm_out  out  1  registered PWM of the current PWM level

## Operation

- Per voice state: inc[ACC_W], phase[ACC_W], mode[2] (0 off, 1 square, 2 saw, 3 triangle), vol[2] (right-shift attenuation).
- Writes: wr_addr=0 → inc = wr_data; phase untouched. wr_addr=1 → mode = wr_data[1:0], vol = wr_data[3:2]; writing mode 0 also clears that voice's phase. Takes effect at the next edge.
- Divider: div_cnt counts 0..2^OUT_W−1, wraps. Tick = cycle where div_cnt = 2^OUT_W−1.
- Waveform from phase P before update, top bits T = P[ACC_W−1 -: OUT_W]: off → 0; square → P[MSB] ? all-ones : 0; saw → T; triangle → t = P[ACC_W−2 -: OUT_W], out = P[MSB] ? ~t : t.
- Voice value = wave >> vol.
- FSM: IDLE → (tick) ACCUM. ACCUM visits voice i = 0..NUM_VOICES−1, one per cycle: acc += voice value (acc cleared on entry, width OUT_W+log2(NUM_VOICES), never overflows); same cycle phase_i ← phase_i + inc_i mod 2^ACC_W, only if mode_i ≠ 0. After last voice → DONE: sample ← acc >> log2(NUM_VOICES), sample_valid = 1 → IDLE.
- Write to a voice during ACCUM: used only if it lands before that voice's visit cycle; a write in the same cycle as the visit wins over the phase update for phase clear; inc write does not affect that visit.
- PWM: pwm_level ← sample at each tick; pwm_out ← (div_cnt < pwm_level). Duty = pwm_level / 2^OUT_W; level 0 → constantly low.

## Timing

- Reset: all inc/phase/mode/vol = 0, div_cnt = 0, FSM IDLE, acc = 0, sample = 0, sample_valid = 0, pwm_level = 0, pwm_out = 0.
- Tick at cycle T → ACCUM cycles T+1..T+N (N = NUM_VOICES) → sample/sample_valid visible at cycle T+N+1; sample_valid high exactly that cycle. First tick after reset at cycle 2^OUT_W−1.
- Exactly one sample_valid per sample period; phases advance exactly once per period.
- New sample reaches PWM at the following tick; pwm_out lags div_cnt comparison by one cycle.
- rst asserted in any state (incl. mid-ACCUM) aborts: no sample_valid for that period, all state returns to reset values next edge.

## Test plan

- Reset, no writes, run 2 periods (N=4, OUT_W=8, ACC_W=16): sample_valid at cycles 260 and 516, sample = 0, pwm_out always 0.
- Voice 0 square, inc=0x8000, vol 0: samples 0, 63, 0, 63…; pwm_out high 63 of 256 cycles during periods with level 63.
- Voice 1 saw, inc=0x0100: successive samples 0,0,0,0,1,1,1,1,2… (k>>2); after 256 periods phase wraps and samples restart at 0.
- All four voices square inc=0x8000, vol 0: second sample = 1020>>2 = 255; pwm_out high 255 of 256 cycles; then voice 0 vol=2: sample = (63+765)>>2 = 207.
- Voice 2 triangle, inc=0x4000: waves 0,128,255,127 (>>2 → 0,32,63,31); writing mode 0 mid-run clears phase, re-enabling triangle restarts at 0.
- Assert rst at cycle T+2 of ACCUM: no sample_valid that period, sample = 0, all voices off, next sample_valid 260 cycles after rst released.
